// File: rtl/msk_romulus_seq.sv
// Block sequencer for the masked Skinny-128-384+ core in Romulus-N: builds TK1 from an LFSR
// block counter, launches or chains core runs, and buffers CT shares in a 2-entry FIFO.
module msk_romulus_seq #(
  parameter int unsigned D = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [7:0]       blk_dom,
  input  logic             blk_ctr_rst,
  input  logic             blk_final,
  input  logic [127:0]     blk_tk2,
  input  logic [128*D-1:0] blk_pt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*D-1:0] out_ct,
  output logic             out_final,
  output logic             busy,
  output logic             core_reset,
  output logic             core_start,
  output logic             core_last,
  output logic [127:0]     core_tk1,
  output logic [127:0]     core_tk2,
  output logic [128*D-1:0] core_pt,
  input  logic [128*D-1:0] core_ct,
  input  logic             core_done,
  output logic             proto_err
);

  localparam int unsigned W = 128 * D;

  typedef enum logic {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [55:0]    ctr_q, ctr_d;  // counter used by the next block that does not restart
  logic           stg_valid_q, stg_valid_d;
  logic [127:0]   stg_tk1_q, stg_tk1_d;
  logic [127:0]   stg_tk2_q, stg_tk2_d;
  logic [W-1:0]   stg_pt_q, stg_pt_d;
  logic           stg_final_q, stg_final_d;
  logic           inf_final_q, inf_final_d;
  logic [W-1:0]   fifo_ct_q [2];
  logic [W-1:0]   fifo_ct_d [2];
  logic [1:0]     fifo_final_q, fifo_final_d;
  logic [1:0]     fifo_cnt_q, fifo_cnt_d;
  logic           perr_q, perr_d;
  logic           accept, pop, push, take;
  logic [1:0]     cnt_after_pop;
  logic [55:0]    ctr_use;

  function automatic logic [55:0] lfsr_step(input logic [55:0] c);
    return {c[54:0], 1'b0} ^ (c[55] ? 56'h95 : 56'h0);
  endfunction

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    stg_valid_d  = stg_valid_q;
    stg_tk1_d    = stg_tk1_q;
    stg_tk2_d    = stg_tk2_q;
    stg_pt_d     = stg_pt_q;
    stg_final_d  = stg_final_q;
    inf_final_d  = inf_final_q;
    fifo_ct_d    = fifo_ct_q;
    fifo_final_d = fifo_final_q;
    perr_d       = perr_q;
    core_start   = 1'b0;
    core_last    = 1'b1;
    push         = 1'b0;
    take         = 1'b0;

    accept        = blk_valid & blk_ready;
    pop           = out_valid & out_ready;
    cnt_after_pop = fifo_cnt_q - {1'b0, pop};
    ctr_use       = blk_ctr_rst ? 56'h1 : ctr_q;

    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (core_done) perr_d = 1'b1;
          // Launching needs a free FIFO slot for the CT this run will produce.
          if (stg_valid_q && cnt_after_pop <= 2'd1) begin
            core_start = 1'b1;
            take       = 1'b1;
            state_d    = StRun;
          end
        end
        StRun: begin
          if (core_done) begin
            push = 1'b1;
            // Chain only if the FIFO keeps a slot free for the chained block's CT.
            if (stg_valid_q && cnt_after_pop == 2'd0) begin
              core_last = 1'b0;
              take      = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      endcase
    end

    if (take) begin
      stg_valid_d = 1'b0;
      inf_final_d = stg_final_q;
    end

    if (accept) begin
      stg_valid_d = 1'b1;
      stg_tk1_d   = {ctr_use, blk_dom, 64'h0};
      stg_tk2_d   = blk_tk2;
      stg_pt_d    = blk_pt;
      stg_final_d = blk_final;
      ctr_d       = lfsr_step(ctr_use);
    end

    if (pop) begin
      fifo_ct_d[0]    = fifo_ct_q[1];
      fifo_final_d[0] = fifo_final_q[1];
    end
    if (push) begin
      fifo_ct_d[cnt_after_pop[0]]    = core_ct;
      fifo_final_d[cnt_after_pop[0]] = inf_final_q;
    end
    fifo_cnt_d = cnt_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ctr_q        <= 56'h1;
      stg_valid_q  <= 1'b0;
      stg_tk1_q    <= '0;
      stg_tk2_q    <= '0;
      stg_pt_q     <= '0;
      stg_final_q  <= 1'b0;
      inf_final_q  <= 1'b0;
      fifo_ct_q[0] <= '0;
      fifo_ct_q[1] <= '0;
      fifo_final_q <= '0;
      fifo_cnt_q   <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      stg_valid_q  <= stg_valid_d;
      stg_tk1_q    <= stg_tk1_d;
      stg_tk2_q    <= stg_tk2_d;
      stg_pt_q     <= stg_pt_d;
      stg_final_q  <= stg_final_d;
      inf_final_q  <= inf_final_d;
      fifo_ct_q[0] <= fifo_ct_d[0];
      fifo_ct_q[1] <= fifo_ct_d[1];
      fifo_final_q <= fifo_final_d;
      fifo_cnt_q   <= fifo_cnt_d;
      perr_q       <= perr_d;
    end
  end

  assign blk_ready  = !stg_valid_q && !reset;
  assign out_valid  = fifo_cnt_q != 2'd0;
  assign out_ct     = out_valid ? fifo_ct_q[0] : '0;
  assign out_final  = out_valid & fifo_final_q[0];
  assign busy       = stg_valid_q | (state_q == StRun) | out_valid;
  assign core_reset = reset;
  assign core_tk1   = stg_tk1_q;
  assign core_tk2   = stg_tk2_q;
  assign core_pt    = stg_pt_q;
  assign proto_err  = perr_q;

  credit_a: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, fifo_cnt_q} + {2'b0, state_q == StRun}) <= 3'd2);
  push_full_a: assert property (@(posedge clk) disable iff (reset)
    !(push && cnt_after_pop == 2'd2));

endmodule

// File: tb/tb_msk_romulus_seq.sv
// Bench for msk_romulus_seq: a fixed-latency stand-in core, a descriptor feeder and a
// scoreboard that derives counters, TK1 and CT from the block order alone.
module tb_msk_romulus_seq;

  localparam int Lat = 4;

  typedef struct {
    logic [7:0]   dom;
    logic         rst;
    logic         fin;
    logic [127:0] tk2;
    logic [255:0] pt;
  } desc_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid, blk_ready, blk_ctr_rst, blk_final;
  logic [7:0]   blk_dom;
  logic [127:0] blk_tk2;
  logic [255:0] blk_pt;
  logic         out_valid, out_ready, out_final, busy;
  logic [255:0] out_ct;
  logic         core_reset, core_start, core_last, core_done, proto_err;
  logic [127:0] core_tk1, core_tk2;
  logic [255:0] core_pt, core_ct;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc = 0;
  int acc_cyc = 0;
  int core_err = 0;
  int kidx;

  desc_t        dq[$];
  logic [127:0] exp_tk1_q[$];
  logic [255:0] exp_ct_q[$];
  logic         exp_fin_q[$];
  logic [127:0] launch_q[$];
  logic [255:0] got_ct_q[$];
  logic         got_fin_q[$];
  logic         done_last_q[$];

  // Stand-in core state
  logic         cbusy = 1'b0;
  int           ccnt = 0;
  logic [127:0] c_tk1, c_tk2;
  logic [255:0] c_pt;
  logic         spur = 1'b0;

  msk_romulus_seq #(.D(2)) dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_dom(blk_dom),
    .blk_ctr_rst(blk_ctr_rst), .blk_final(blk_final), .blk_tk2(blk_tk2), .blk_pt(blk_pt),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .out_final(out_final),
    .busy(busy), .core_reset(core_reset), .core_start(core_start), .core_last(core_last),
    .core_tk1(core_tk1), .core_tk2(core_tk2), .core_pt(core_pt), .core_ct(core_ct),
    .core_done(core_done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the Skinny permutation: a keyed mixing of the staged data.
  function automatic logic [255:0] fcore(input logic [127:0] tk1, input logic [127:0] tk2,
                                         input logic [255:0] pt);
    return {pt[255:128] ^ {tk1[63:0], tk1[127:64]} ^ ~tk2, pt[127:0] ^ tk1 ^ tk2};
  endfunction

  // x^k in GF(2)[x] / (x^56 + x^7 + x^4 + x^2 + 1)
  function automatic logic [55:0] xpow(input int k);
    logic [56:0] v = 57'h1;
    for (int i = 0; i < k; i++) begin
      v = v << 1;
      if (v[56]) v = v ^ 57'h1_00000000_000095;
    end
    return v[55:0];
  endfunction

  assign core_done = (cbusy && ccnt == 0) || spur;
  assign core_ct   = (cbusy && ccnt == 0) ? fcore(c_tk1, c_tk2, c_pt) : {8{32'hdeadbeef}};

  always @(posedge clk) begin
    if (core_reset) begin
      cbusy <= 1'b0;
      ccnt  <= 0;
    end else if (cbusy) begin
      if (core_start) core_err <= core_err + 1;
      if (ccnt == 0) begin
        if (!core_last) begin
          c_tk1 <= core_tk1; c_tk2 <= core_tk2; c_pt <= core_pt;
          ccnt  <= Lat - 1;
          launch_q.push_back(core_tk1);
        end else begin
          cbusy <= 1'b0;
        end
      end else begin
        ccnt <= ccnt - 1;
      end
    end else if (core_start) begin
      c_tk1 <= core_tk1; c_tk2 <= core_tk2; c_pt <= core_pt;
      ccnt  <= Lat - 1;
      cbusy <= 1'b1;
      launch_q.push_back(core_tk1);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (core_start) begin
        n_start   <= n_start + 1;
        start_cyc <= cyc;
      end
      if (core_done && cbusy) done_last_q.push_back(core_last);
      if (out_valid && out_ready) begin
        got_ct_q.push_back(out_ct);
        got_fin_q.push_back(out_final);
      end
    end
  end

  // Feeder: presents dq[0] and records the expected result of every accepted block.
  initial begin : feeder
    logic         acc;
    logic [127:0] tk1;
    desc_t        d;
    blk_valid = 1'b0; blk_dom = '0; blk_ctr_rst = 1'b0; blk_final = 1'b0;
    blk_tk2 = '0; blk_pt = '0; kidx = -1;
    forever begin
      @(negedge clk);
      acc = blk_valid && blk_ready && !reset;
      if (reset) begin
        kidx = -1;
        exp_tk1_q.delete(); exp_ct_q.delete(); exp_fin_q.delete();
      end
      if (acc) begin
        d = dq[0];
        kidx = d.rst ? 0 : kidx + 1;
        tk1 = {xpow(kidx), d.dom, 64'h0};
        exp_tk1_q.push_back(tk1);
        exp_ct_q.push_back(fcore(tk1, d.tk2, d.pt));
        exp_fin_q.push_back(d.fin);
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) void'(dq.pop_front());
      if (dq.size() > 0) begin
        blk_valid = 1'b1; blk_dom = dq[0].dom; blk_ctr_rst = dq[0].rst;
        blk_final = dq[0].fin; blk_tk2 = dq[0].tk2; blk_pt = dq[0].pt;
      end else begin
        blk_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_desc(input logic [7:0] dom, input logic rst, input logic fin);
    desc_t d;
    d.dom = dom; d.rst = rst; d.fin = fin;
    for (int i = 0; i < 4; i++) d.tk2[32*i +: 32] = $urandom();
    for (int i = 0; i < 8; i++) d.pt[32*i +: 32] = $urandom();
    dq.push_back(d);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || blk_valid || dq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 256'(n < budget), 256'(1));
  endtask

  task automatic check_run(input string tag);
    int nl, no;
    chk({tag, "_nlaunch"}, 256'(launch_q.size()), 256'(exp_tk1_q.size()));
    chk({tag, "_nout"}, 256'(got_ct_q.size()), 256'(exp_ct_q.size()));
    nl = (launch_q.size() < exp_tk1_q.size()) ? launch_q.size() : exp_tk1_q.size();
    no = (got_ct_q.size() < exp_ct_q.size()) ? got_ct_q.size() : exp_ct_q.size();
    for (int i = 0; i < nl; i++)
      chk($sformatf("%s_tk1_%0d", tag, i), 256'(launch_q[i]), 256'(exp_tk1_q[i]));
    for (int i = 0; i < no; i++) begin
      chk($sformatf("%s_ct_%0d", tag, i), got_ct_q[i], exp_ct_q[i]);
      chk($sformatf("%s_fin_%0d", tag, i), 256'(got_fin_q[i]), 256'(exp_fin_q[i]));
    end
    launch_q.delete(); got_ct_q.delete(); got_fin_q.delete(); done_last_q.delete();
    exp_tk1_q.delete(); exp_ct_q.delete(); exp_fin_q.delete();
  endtask

  task automatic single_block(input string tag);
    int s0 = n_start;
    push_desc(8'h08, 1'b1, 1'b1);
    wait_idle(tag, 200);
    chk({tag, "_starts"}, 256'(n_start - s0), 256'(1));
    chk({tag, "_ndone"}, 256'(done_last_q.size()), 256'(1));
    if (done_last_q.size() > 0) chk({tag, "_last"}, 256'(done_last_q[0]), 256'(1));
    if (launch_q.size() > 0) chk({tag, "_tk1c"}, 256'(launch_q[0]), 256'({56'h1, 8'h08, 64'h0}));
    if (got_fin_q.size() > 0) chk({tag, "_final"}, 256'(got_fin_q[0]), 256'(1));
    check_run(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 256'(blk_ready), 256'(0));
    chk({tag, "_oval"}, 256'(out_valid), 256'(0));
    chk({tag, "_ofin"}, 256'(out_final), 256'(0));
    chk({tag, "_oct"}, out_ct, 256'(0));
    chk({tag, "_start"}, 256'(core_start), 256'(0));
    chk({tag, "_last"}, 256'(core_last), 256'(1));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_creset"}, 256'(core_reset), 256'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin : main
    int s0, n;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    chk("rst_perr", 256'(proto_err), 256'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 256'(blk_ready), 256'(1));
    chk("rel_creset", 256'(core_reset), 256'(0));

    // Single block
    single_block("s1");

    // Three back-to-back blocks: one launch, then two chains
    s0 = n_start;
    push_desc(8'h04, 1'b1, 1'b0);
    push_desc(8'h04, 1'b0, 1'b0);
    push_desc(8'h05, 1'b0, 1'b1);
    wait_idle("s2", 200);
    chk("s2_starts", 256'(n_start - s0), 256'(1));
    chk("s2_ndone", 256'(done_last_q.size()), 256'(3));
    if (done_last_q.size() == 3) begin
      chk("s2_last0", 256'(done_last_q[0]), 256'(0));
      chk("s2_last1", 256'(done_last_q[1]), 256'(0));
      chk("s2_last2", 256'(done_last_q[2]), 256'(1));
    end
    if (launch_q.size() == 3) begin
      chk("s2_ctr0", 256'(launch_q[0][127:72]), 256'(56'h1));
      chk("s2_ctr1", 256'(launch_q[1][127:72]), 256'(56'h2));
      chk("s2_ctr2", 256'(launch_q[2][127:72]), 256'(56'h4));
    end
    check_run("s2");

    // Counter wrap over 57 chained blocks
    s0 = n_start;
    for (int i = 0; i < 57; i++) push_desc(8'(i), i == 0, i == 56);
    wait_idle("s3", 2000);
    chk("s3_starts", 256'(n_start - s0), 256'(1));
    if (launch_q.size() == 57) begin
      chk("s3_ctr55", 256'(launch_q[55][127:72]), 256'(56'h80_0000_0000_0000));
      chk("s3_ctr56", 256'(launch_q[56][127:72]), 256'(56'h95));
    end
    check_run("s3");

    // Backpressure: two CTs buffered, third block held until a pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_desc(8'h10 + 8'(i), i == 0, i == 3);
    repeat (40) @(negedge clk);
    chk("s4_nlaunch_held", 256'(launch_q.size()), 256'(2));
    chk("s4_nout_held", 256'(got_ct_q.size()), 256'(0));
    chk("s4_oval", 256'(out_valid), 256'(1));
    chk("s4_ready", 256'(blk_ready), 256'(0));
    chk("s4_pending", 256'(dq.size()), 256'(1));
    out_ready = 1'b1;
    wait_idle("s4", 300);
    check_run("s4");

    // Late descriptor: core goes idle, then relaunches one cycle after acceptance
    push_desc(8'h20, 1'b1, 1'b0);
    n = 0;
    while (done_last_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s5_first_done", 256'(n < 100), 256'(1));
    repeat (10) @(negedge clk);
    push_desc(8'h21, 1'b0, 1'b1);
    wait_idle("s5", 200);
    if (done_last_q.size() > 0) chk("s5_last0", 256'(done_last_q[0]), 256'(1));
    chk("s5_lat", 256'(start_cyc - acc_cyc), 256'(1));
    check_run("s5");

    // Reset in the middle of a run
    s0 = n_start;
    push_desc(8'h33, 1'b1, 1'b1);
    n = 0;
    while (n_start == s0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s6_launched", 256'(n < 100), 256'(1));
    @(negedge clk);
    reset = 1'b1;
    dq.delete();
    @(negedge clk);
    check_reset_values("s6_rst");
    launch_q.delete(); got_ct_q.delete(); got_fin_q.delete(); done_last_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("s6_ready", 256'(blk_ready), 256'(1));
    single_block("s6");

    // core_done while idle is ignored but flagged
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("s7_perr", 256'(proto_err), 256'(1));
    chk("s7_oval", 256'(out_valid), 256'(0));
    chk("s7_busy", 256'(busy), 256'(0));

    chk("core_overlap", 256'(core_err), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
